// File: rtl/pme_irq_ctrl.sv
// PME wake/SCI interrupt manager: sticky status, saturating event count, and an
// assert/holdoff FSM driving active-low pme_irq_n. Optional timeout via PME_IRQ_TIMEOUT_EN.
module pme_irq_ctrl #(
    parameter int CNT_W         = 8,
    parameter int TIMEOUT_TICKS = 16,
    parameter int HOLDOFF_TICKS = 4
) (
    input  logic             clk,
    input  logic             pgoodaux,
    input  logic             t1ms_tick,
    input  logic             pme_event_pls,
    input  logic             db_pme_source_all,
    input  logic             irq_en,
    input  logic             status_w1c,
    input  logic             irq_ack,
    output logic             pme_irq_n,
    output logic             pme_status,
    output logic             pme_pending,
    output logic [CNT_W-1:0] pme_evt_cnt,
    output logic             pme_timeout_err
);

    localparam int MAX_TICKS = (TIMEOUT_TICKS > HOLDOFF_TICKS) ? TIMEOUT_TICKS : HOLDOFF_TICKS;
    localparam int TICK_W    = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [TICK_W-1:0] tick_cnt;
    logic              ack_take;
    logic              holdoff_done;
    logic              retrig;
`ifdef PME_IRQ_TIMEOUT_EN
    logic              timeout_hit;
`endif

    // Priority inside ASSERT: irq_en low, then ack, then timeout.
    always_comb begin
        state_nxt    = state;
        ack_take     = 1'b0;
        holdoff_done = 1'b0;
`ifdef PME_IRQ_TIMEOUT_EN
        timeout_hit  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (pme_pending && irq_en) state_nxt = ASSERT;
            end
            ASSERT: begin
                if (!irq_en) begin
                    state_nxt = IDLE;
                end else if (irq_ack) begin
                    ack_take  = 1'b1;
                    state_nxt = HOLDOFF;
                end
`ifdef PME_IRQ_TIMEOUT_EN
                else if (t1ms_tick && tick_cnt == TICK_W'(TIMEOUT_TICKS - 1)) begin
                    timeout_hit = 1'b1;
                    state_nxt   = HOLDOFF;
                end
`endif
            end
            HOLDOFF: begin
                if (t1ms_tick && tick_cnt == TICK_W'(HOLDOFF_TICKS - 1)) begin
                    holdoff_done = 1'b1;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A source still held high when holdoff ends re-arms the request.
    assign retrig = holdoff_done & db_pme_source_all;

    always_ff @(posedge clk or negedge pgoodaux) begin
        if (!pgoodaux) begin
            state     <= IDLE;
            pme_irq_n <= 1'b1;
            tick_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            pme_irq_n <= (state_nxt != ASSERT);
            if (state_nxt != state) begin
                tick_cnt <= '0;
            end else if (t1ms_tick && state != IDLE) begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge pgoodaux) begin
        if (!pgoodaux) begin
            pme_pending <= 1'b0;
            pme_status  <= 1'b0;
            pme_evt_cnt <= '0;
        end else begin
            if (pme_event_pls || retrig) begin
                pme_pending <= 1'b1;
            end else if (ack_take || status_w1c) begin
                pme_pending <= 1'b0;
            end
            if (pme_event_pls) begin
                pme_status <= 1'b1;
            end else if (status_w1c) begin
                pme_status <= 1'b0;
            end
            if (status_w1c) begin
                pme_evt_cnt <= {{(CNT_W-1){1'b0}}, pme_event_pls};
            end else if (pme_event_pls && !(&pme_evt_cnt)) begin
                pme_evt_cnt <= pme_evt_cnt + 1'b1;
            end
        end
    end

`ifdef PME_IRQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge pgoodaux) begin
        if (!pgoodaux) begin
            pme_timeout_err <= 1'b0;
        end else if (timeout_hit) begin
            pme_timeout_err <= 1'b1;
        end else if (status_w1c) begin
            pme_timeout_err <= 1'b0;
        end
    end
`else
    assign pme_timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_pme_irq_ctrl.sv
// Directed bench for pme_irq_ctrl: expected output snapshots are queued when
// stimulus is applied and popped/compared once the DUT has reacted.
module tb_pme_irq_ctrl;
  localparam int CNT_W = 8;
  localparam int W     = CNT_W + 4;

  logic clk = 1'b0;
  logic pgoodaux, t1ms_tick, pme_event_pls, db_pme_source_all;
  logic irq_en, status_w1c, irq_ack;
  logic pme_irq_n, pme_status, pme_pending, pme_timeout_err;
  logic [CNT_W-1:0] pme_evt_cnt;

  // expected model state
  logic e_irq_n, e_status, e_pend, e_err;
  logic [CNT_W-1:0] e_cnt;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int vectors = 0;
  int miscompares = 0;

  pme_irq_ctrl #(.CNT_W(CNT_W), .TIMEOUT_TICKS(16), .HOLDOFF_TICKS(4)) dut (
    .clk(clk), .pgoodaux(pgoodaux), .t1ms_tick(t1ms_tick),
    .pme_event_pls(pme_event_pls), .db_pme_source_all(db_pme_source_all),
    .irq_en(irq_en), .status_w1c(status_w1c), .irq_ack(irq_ack),
    .pme_irq_n(pme_irq_n), .pme_status(pme_status), .pme_pending(pme_pending),
    .pme_evt_cnt(pme_evt_cnt), .pme_timeout_err(pme_timeout_err)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      t1ms_tick = 1'b1;
      cyc(1);
      t1ms_tick = 1'b0;
      cyc($urandom_range(0, 2));
    end
  endtask

  task automatic pulse_pls();
    pme_event_pls = 1'b1;
    cyc(1);
    pme_event_pls = 1'b0;
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1;
    cyc(1);
    irq_ack = 1'b0;
  endtask

  // scoreboard
  task automatic push_exp(input string tag);
    exp_q.push_back({e_irq_n, e_status, e_pend, e_err, e_cnt});
    tag_q.push_back(tag);
  endtask

  task automatic check_out();
    logic [W-1:0] exp_v, obs_v;
    string        tag;
    exp_v = exp_q.pop_front();
    tag   = tag_q.pop_front();
    obs_v = {pme_irq_n, pme_status, pme_pending, pme_timeout_err, pme_evt_cnt};
    vectors++;
    assert (obs_v === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed {irq_n,status,pend,err,cnt}=%b_%b_%b_%b_%0d expected %b_%b_%b_%b_%0d",
             tag, obs_v[W-1], obs_v[W-2], obs_v[W-3], obs_v[W-4], obs_v[CNT_W-1:0],
             exp_v[W-1], exp_v[W-2], exp_v[W-3], exp_v[W-4], exp_v[CNT_W-1:0]);
    end
  endtask

  task automatic expect_now(input string tag);
    push_exp(tag);
    check_out();
  endtask

  task automatic model_reset();
    e_irq_n = 1'b1; e_status = 1'b0; e_pend = 1'b0; e_err = 1'b0; e_cnt = '0;
  endtask

  initial begin
    pgoodaux = 1'b0; t1ms_tick = 1'b0; pme_event_pls = 1'b0; db_pme_source_all = 1'b0;
    irq_en = 1'b0; status_w1c = 1'b0; irq_ack = 1'b0;
    model_reset();
    cyc(3);
    expect_now("reset");
    pgoodaux = 1'b1;
    cyc(2);

    // single event: pending at +1, irq asserted at +2
    irq_en = 1'b1;
    push_exp("evt_pend");
    e_pend = 1'b1; e_status = 1'b1; e_cnt = 1;
    exp_q[$] = {e_irq_n, e_status, e_pend, e_err, e_cnt};
    pulse_pls();
    check_out();
    cyc(1);
    e_irq_n = 1'b0;
    expect_now("evt_assert");

    // ack releases interrupt and clears pending at the same edge
    pulse_ack();
    e_irq_n = 1'b1; e_pend = 1'b0;
    expect_now("ack");
    ticks(4);
    cyc(2);
    expect_now("holdoff_src_low_idle");

    // status_w1c clears status and count
    status_w1c = 1'b1;
    cyc(1);
    status_w1c = 1'b0;
    e_status = 1'b0; e_cnt = 0;
    expect_now("w1c");

    // level re-trigger after holdoff
    db_pme_source_all = 1'b1;
    pulse_pls();
    e_status = 1'b1; e_pend = 1'b1; e_cnt = 1;
    cyc(1);
    e_irq_n = 1'b0;
    expect_now("retrig_assert");
    pulse_ack();
    e_irq_n = 1'b1; e_pend = 1'b0;
    expect_now("retrig_ack");
    ticks(3);
    expect_now("retrig_holdoff_3");
    t1ms_tick = 1'b1;
    cyc(1);
    t1ms_tick = 1'b0;
    e_pend = 1'b1;
    expect_now("retrig_pend");
    cyc(1);
    e_irq_n = 1'b0;
    expect_now("retrig_reassert");
    db_pme_source_all = 1'b0;
    pulse_ack();
    e_irq_n = 1'b1; e_pend = 1'b0;
    ticks(4);
    cyc(2);
    expect_now("src_low_stays_idle");

    // no ack: timeout behaviour depends on build
    pulse_pls();
    e_pend = 1'b1; e_cnt = 2;
    cyc(1);
    e_irq_n = 1'b0;
    ticks(15);
    expect_now("pre_timeout");
`ifdef PME_IRQ_TIMEOUT_EN
    t1ms_tick = 1'b1;
    cyc(1);
    t1ms_tick = 1'b0;
    e_irq_n = 1'b1; e_err = 1'b1;
    expect_now("timeout");
    ticks(4);
    expect_now("timeout_holdoff_done");
    cyc(1);
    e_irq_n = 1'b0;
    expect_now("timeout_reassert");
`else
    ticks(10);
    expect_now("no_timeout_held");
`endif
    pulse_ack();
    e_irq_n = 1'b1; e_pend = 1'b0;
    expect_now("late_ack");
    ticks(4);

    // irq_en dropped in ASSERT keeps pending
    pulse_pls();
    e_pend = 1'b1; e_cnt = 3;
    cyc(1);
    e_irq_n = 1'b0;
    expect_now("en_assert");
    irq_en = 1'b0;
    cyc(1);
    e_irq_n = 1'b1;
    expect_now("en_drop");
    cyc(3);
    expect_now("en_drop_held");
    irq_en = 1'b1;
    cyc(1);
    e_irq_n = 1'b0;
    expect_now("en_reraise");

    // async reset mid-ASSERT
    #2 pgoodaux = 1'b0;
    #1;
    model_reset();
    expect_now("async_reset");
    cyc(1);
    pgoodaux = 1'b1;
    irq_en = 1'b0;
    cyc(1);

    // counter saturation
    pme_event_pls = 1'b1;
    cyc(254);
    e_status = 1'b1; e_pend = 1'b1; e_cnt = 254;
    expect_now("cnt_254");
    cyc(46);
    pme_event_pls = 1'b0;
    e_cnt = 255;
    expect_now("cnt_sat");

    // clear and event in the same cycle: set wins
    status_w1c = 1'b1;
    pme_event_pls = 1'b1;
    cyc(1);
    status_w1c = 1'b0;
    pme_event_pls = 1'b0;
    e_cnt = 1;
    expect_now("w1c_collide");
    status_w1c = 1'b1;
    cyc(1);
    status_w1c = 1'b0;
    e_status = 1'b0; e_pend = 1'b0; e_cnt = 0;
    expect_now("w1c_final");

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pme_irq_ctrl.md
# pme_irq_ctrl

Downstream consumer of the debounced PME path: takes the 1-clock `pme_event_pls` and the debounced level `db_pme_source_all` from the PME filter stage and turns them into a managed active-low wake/SCI interrupt toward the PCH. Holds sticky status and a saturating event count for the XREG block, asserts the interrupt until software/host acknowledges or a timeout expires, then enforces a holdoff before re-arming. Runs on the aux power domain clock, reset by `pgoodaux`.

## Interface
- `CNT_W`, 8: event counter width (≥2).
- `TIMEOUT_TICKS`, 16: `t1ms_tick` count allowed in ASSERT without ack (≥1).
- `HOLDOFF_TICKS`, 4: `t1ms_tick` count of forced deassertion after ASSERT (≥1).

- `clk`  in  1  aux-domain clock.
- `pgoodaux`  in  1  asynchronous, active-low reset.
- `t1ms_tick`  in  1  1-clock strobe, once per ms.
- `pme_event_pls`  in  1  1-clock debounced PME rising event.
- `db_pme_source_all`  in  1  debounced PME level.
- `irq_en`  in  1  XREG interrupt enable (level).
- `status_w1c`  in  1  1-clock clear of status, count, timeout flag.
- `irq_ack`  in  1  1-clock host acknowledge.
- `pme_irq_n`  out  1  registered active-low interrupt.
- `pme_status`  out  1  sticky event-seen flag.
- `pme_pending`  out  1  event awaiting service.
- `pme_evt_cnt`  out  CNT_W  saturating event count.
- `pme_timeout_err`  out  1  sticky: ASSERT ended by timeout.

## Operation
- Reset values: `pme_irq_n`=1, `pme_status`=0, `pme_pending`=0, `pme_evt_cnt`=0, `pme_timeout_err`=0, state IDLE, tick counter 0.
- `pme_pending`: set by `pme_event_pls`; cleared by `irq_ack` while in ASSERT or by `status_w1c`. Set and clear same cycle: set wins.
- `pme_status`: set by `pme_event_pls`, cleared only by `status_w1c`; set wins on collision.
- `pme_evt_cnt`: +1 per `pme_event_pls`, saturates at all-ones; `status_w1c` clears; clear+event same cycle → 1.
- FSM (3 states):
  - IDLE: `pme_irq_n`=1. `pme_pending`&`irq_en` → ASSERT.
  - ASSERT: `pme_irq_n`=0; tick counter counts `t1ms_tick`. `irq_ack` → HOLDOFF. Timeout → HOLDOFF, set `pme_timeout_err`, pending retained. `irq_en`=0 → IDLE, pending retained. Priority: `irq_en`=0 > `irq_ack` > timeout.
  - HOLDOFF: `pme_irq_n`=1; counts HOLDOFF_TICKS ticks → IDLE. On exit, if `db_pme_source_all`=1, set `pme_pending` (level re-trigger).
- `irq_ack` outside ASSERT ignored. Tick counter cleared on every state entry; width sized for max(TIMEOUT_TICKS, HOLDOFF_TICKS).
- Reset mid-operation: all outputs return to reset values immediately (async), `pme_irq_n` deasserts.

## Timing
- `pme_event_pls` at edge N (irq_en=1, IDLE): `pme_pending`=1 after N+1, state ASSERT and `pme_irq_n`=0 after N+2.
- `pme_irq_n` is registered, updated on the same edge as the state register; no combinational path from inputs.
- `irq_ack` sampled at edge M in ASSERT: HOLDOFF, `pme_irq_n`=1, `pme_pending`=0 after M.
- Timeout: edge where `t1ms_tick`=1 and count==TIMEOUT_TICKS-1 moves to HOLDOFF; same for HOLDOFF_TICKS out of HOLDOFF.
- `status_w1c` effect visible one cycle after strobe.

## Configuration
- `PME_IRQ_TIMEOUT_EN` defined: timeout path as above.
- Undefined: ASSERT exits only via `irq_ack` or `irq_en`=0; `pme_timeout_err` tied 0; TIMEOUT_TICKS unused.

## Test plan
- Reset then one `pme_event_pls`, irq_en=1 → pending=1 at +1, `pme_irq_n`=0 at +2, cnt=1, status=1; ack → irq_n=1 next cycle, pending=0.
- No ack, TIMEOUT_TICKS=16 (macro on) → irq_n high after 16th tick, timeout_err=1, pending=1, re-asserts after 4 holdoff ticks; macro off → irq_n stays 0 indefinitely.
- 300 events with CNT_W=8 → cnt=255; `status_w1c` same cycle as an event → cnt=1, status=1.
- Ack while `db_pme_source_all`=1 held → after 4 holdoff ticks pending=1, irq_n=0 one cycle later; source low → stays IDLE.
- irq_en dropped in ASSERT → irq_n=1 next cycle, pending kept; irq_en re-raised → ASSERT; `pgoodaux` low mid-ASSERT → all outputs at reset values immediately.
